// File: rtl/apb_txn_pkg.sv
// Shared types and default widths for the transaction arbiter.
package apb_txn_pkg;

    localparam int unsigned DEF_NUM_REQ    = 2;
    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_RD_TIMEOUT = 255;

    // Largest supported requester count and the index width it needs.
    localparam int unsigned MAX_NUM_REQ = 4;
    localparam int unsigned MAX_PTR_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_t;

    // Encode a one-hot vector into its bit index (0 for an all-zero vector).
    function automatic logic [MAX_PTR_W-1:0] onehot_to_idx(input logic [MAX_NUM_REQ-1:0] onehot);
        logic [MAX_PTR_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_NUM_REQ; i++) begin
            if (onehot[i]) begin
                idx = MAX_PTR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/txn_arbiter_rr_picker.sv
// Round-robin winner selection: first requester after last_ptr, wrapping.
module rr_picker
    import apb_txn_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   last_ptr,
    output logic [NUM_REQ-1:0] winner_c
);

    logic [PTR_W-1:0] cand;
    logic             found;

    // Scan candidates in priority order starting just after the last winner.
    always_comb begin
        winner_c = '0;
        found    = 1'b0;
        cand     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((32'(last_ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                winner_c[cand] = 1'b1;
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/txn_arbiter.sv
// Round-robin arbiter that forwards one requester's transaction at a time to a
// single target and routes the read return (or a timeout error) back to it.
module txn_arbiter
    import apb_txn_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned RD_TIMEOUT = DEF_RD_TIMEOUT
) (
    input  logic                          i_clk_apb,
    input  logic                          i_rstn_apb,
    // requester side
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ-1:0]            i_req_rd0_wr1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wr_data,
    output logic [NUM_REQ-1:0]            o_req_rd_valid,
    output logic [DATA_WIDTH-1:0]         o_req_rd_data,
    output logic [NUM_REQ-1:0]            o_req_err,
    // target side
    output logic                          o_valid,
    output logic [ADDR_WIDTH-1:0]         o_addr,
    output logic                          o_rd0_wr1,
    output logic [DATA_WIDTH-1:0]         o_wr_data,
    input  logic                          i_ready,
    input  logic                          i_rd_valid,
    input  logic [DATA_WIDTH-1:0]         i_rd_data,
    // current grant
    output logic [NUM_REQ-1:0]            o_grant
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_TIMEOUT);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]    gidx_q, gidx_d;
    logic [PTR_W-1:0]    last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  winner_c;
    logic [PTR_W-1:0]    winner_idx_c;
    logic                req_sel_c;
    logic                rw_sel_c;
    logic [ADDR_WIDTH-1:0] addr_sel_c;
    logic [DATA_WIDTH-1:0] wdata_sel_c;
    logic                release_c;

    logic                  valid_c;
    logic [ADDR_WIDTH-1:0] addr_c;
    logic                  rd0_wr1_c;
    logic [DATA_WIDTH-1:0] wr_data_c;
    logic [NUM_REQ-1:0]    req_ready_c;
    logic [NUM_REQ-1:0]    rd_valid_c;
    logic [DATA_WIDTH-1:0] rd_data_c;
    logic [NUM_REQ-1:0]    err_c;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .req      (i_req_valid),
        .last_ptr (last_ptr_q),
        .winner_c (winner_c)
    );

    assign winner_idx_c = PTR_W'(onehot_to_idx(MAX_NUM_REQ'(winner_c)));

    // Fields of the currently granted requester.
    assign req_sel_c   = i_req_valid[gidx_q];
    assign rw_sel_c    = i_req_rd0_wr1[gidx_q];
    assign addr_sel_c  = i_req_addr[32'(gidx_q)*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_sel_c = i_req_wr_data[32'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];

    // State, grant, round-robin pointer and read-timeout counter.
    always_ff @(posedge i_clk_apb) begin
        if (!i_rstn_apb) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            last_ptr_q <= PTR_W'(NUM_REQ - 1);
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            last_ptr_q <= last_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic and the combinational forwarding/return paths.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        last_ptr_d  = last_ptr_q;
        cnt_d       = cnt_q;
        release_c   = 1'b0;
        valid_c     = 1'b0;
        addr_c      = '0;
        rd0_wr1_c   = 1'b0;
        wr_data_c   = '0;
        req_ready_c = '0;
        rd_valid_c  = '0;
        rd_data_c   = '0;
        err_c       = '0;

        case (state_q)
            IDLE: begin
                if (|i_req_valid) begin
                    grant_d = winner_c;
                    gidx_d  = winner_idx_c;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                valid_c             = req_sel_c;
                addr_c              = addr_sel_c;
                rd0_wr1_c           = rw_sel_c;
                wr_data_c           = wdata_sel_c;
                req_ready_c[gidx_q] = i_ready;
                if (!req_sel_c) begin
                    release_c = 1'b1;
                end else if (i_ready) begin
                    if (rw_sel_c) begin
                        release_c = 1'b1;
                    end else if (i_rd_valid) begin
                        rd_valid_c[gidx_q] = 1'b1;
                        rd_data_c          = i_rd_data;
                        release_c          = 1'b1;
                    end else begin
                        state_d = WAIT_RD;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT_RD: begin
                if (i_rd_valid) begin
                    rd_valid_c[gidx_q] = 1'b1;
                    rd_data_c          = i_rd_data;
                    release_c          = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    rd_valid_c[gidx_q] = 1'b1;
                    err_c[gidx_q]      = 1'b1;
                    release_c          = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // Completion or withdrawal: remember the owner and drop the grant.
        if (release_c) begin
            last_ptr_d = gidx_q;
            grant_d    = '0;
            state_d    = IDLE;
        end
    end

    // Outputs are forced low while reset is held so nothing leaks mid-reset.
    assign o_valid        = i_rstn_apb & valid_c;
    assign o_addr         = i_rstn_apb ? addr_c : '0;
    assign o_rd0_wr1      = i_rstn_apb & rd0_wr1_c;
    assign o_wr_data      = i_rstn_apb ? wr_data_c : '0;
    assign o_req_ready    = {NUM_REQ{i_rstn_apb}} & req_ready_c;
    assign o_req_rd_valid = {NUM_REQ{i_rstn_apb}} & rd_valid_c;
    assign o_req_rd_data  = i_rstn_apb ? rd_data_c : '0;
    assign o_req_err      = {NUM_REQ{i_rstn_apb}} & err_c;
    assign o_grant        = grant_q;

endmodule

// File: tb/tb_txn_arbiter.sv
// Directed bench for txn_arbiter with a transaction-level reference model.
module tb_txn_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_rw;
    logic [AW-1:0] addr [N];
    logic [DW-1:0] wdata [N];
    logic          i_ready;
    logic          i_rd_valid;
    logic [DW-1:0] i_rd_data;

    logic [N*AW-1:0] addr_flat;
    logic [N*DW-1:0] wdata_flat;
    assign addr_flat  = {addr[1], addr[0]};
    assign wdata_flat = {wdata[1], wdata[0]};

    logic [N-1:0]  o_req_ready;
    logic [N-1:0]  o_req_rd_valid;
    logic [DW-1:0] o_req_rd_data;
    logic [N-1:0]  o_req_err;
    logic          o_valid;
    logic [AW-1:0] o_addr;
    logic          o_rd0_wr1;
    logic [DW-1:0] o_wr_data;
    logic [N-1:0]  o_grant;

    txn_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_TIMEOUT (TO)
    ) dut (
        .i_clk_apb      (clk),
        .i_rstn_apb     (rstn),
        .i_req_valid    (req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_addr     (addr_flat),
        .i_req_rd0_wr1  (req_rw),
        .i_req_wr_data  (wdata_flat),
        .o_req_rd_valid (o_req_rd_valid),
        .o_req_rd_data  (o_req_rd_data),
        .o_req_err      (o_req_err),
        .o_valid        (o_valid),
        .o_addr         (o_addr),
        .o_rd0_wr1      (o_rd0_wr1),
        .o_wr_data      (o_wr_data),
        .i_ready        (i_ready),
        .i_rd_valid     (i_rd_valid),
        .i_rd_data      (i_rd_data),
        .o_grant        (o_grant)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the target, whether the read was accepted,
    // how long we have waited for data, and who completed last.
    int m_own   = -1;
    bit m_acc   = 1'b0;
    int m_wait  = 0;
    int m_last  = N - 1;
    bit m_known = 1'b0;

    logic [N-1:0]  e_rdy, e_rdv, e_err, e_gnt;
    logic          e_valid, e_rw;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rdd;
    int            m_pick;

    always @(negedge clk) begin
        e_rdy = '0; e_rdv = '0; e_err = '0; e_gnt = '0;
        e_valid = 1'b0; e_rw = 1'b0; e_addr = '0; e_wd = '0; e_rdd = '0;
        if (m_own >= 0) e_gnt[m_own] = 1'b1;

        if (rstn) begin
            if (m_own < 0) begin
                m_pick = -1;
                for (int i = 1; i <= int'(N); i++) begin
                    if (m_pick < 0 && req_valid[(m_last + i) % N]) m_pick = (m_last + i) % N;
                end
                m_own = m_pick;
                m_acc = 1'b0;
            end else if (!m_acc) begin
                e_valid      = req_valid[m_own];
                e_addr       = addr[m_own];
                e_rw         = req_rw[m_own];
                e_wd         = wdata[m_own];
                e_rdy[m_own] = i_ready;
                if (!req_valid[m_own] || (i_ready && req_rw[m_own])) begin
                    m_last = m_own; m_own = -1;
                end else if (i_ready && i_rd_valid) begin
                    e_rdv[m_own] = 1'b1; e_rdd = i_rd_data;
                    m_last = m_own; m_own = -1;
                end else if (i_ready) begin
                    m_acc = 1'b1; m_wait = 0;
                end
            end else begin
                if (i_rd_valid) begin
                    e_rdv[m_own] = 1'b1; e_rdd = i_rd_data;
                    m_last = m_own; m_own = -1;
                end else if (m_wait == int'(TO)) begin
                    e_rdv[m_own] = 1'b1; e_err[m_own] = 1'b1;
                    m_last = m_own; m_own = -1;
                end else begin
                    m_wait++;
                end
            end
        end

        if (m_known) chk("m_grant", 64'(o_grant), 64'(e_gnt));
        chk("m_valid",    64'(o_valid),        64'(e_valid));
        chk("m_addr",     64'(o_addr),         64'(e_addr));
        chk("m_rw",       64'(o_rd0_wr1),      64'(e_rw));
        chk("m_wdata",    64'(o_wr_data),      64'(e_wd));
        chk("m_ready",    64'(o_req_ready),    64'(e_rdy));
        chk("m_rd_valid", 64'(o_req_rd_valid), 64'(e_rdv));
        chk("m_rd_data",  64'(o_req_rd_data),  64'(e_rdd));
        chk("m_err",      64'(o_req_err),      64'(e_err));

        if (!rstn) begin
            m_own = -1; m_acc = 1'b0; m_wait = 0; m_last = N - 1; m_known = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid  = '0;
        req_rw     = '0;
        i_ready    = 1'b0;
        i_rd_valid = 1'b0;
        i_rd_data  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int gq[$];
    int exp_g[4] = '{0, 1, 0, 1};
    int pulses, pk;
    logic [N-1:0]  pvec, perr;
    logic [DW-1:0] pdata;

    initial begin
        rstn = 1'b0;
        idle_inputs();
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;

        // Reset values
        tick();
        @(negedge clk);
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_grant", 64'(o_grant), 64'(0));
        chk("rst_ready", 64'(o_req_ready), 64'(0));
        tick();
        rstn = 1'b1;

        // Contention: both write continuously, grants must alternate from req0
        req_valid = 2'b11; req_rw = 2'b11; i_ready = 1'b1;
        addr[0] = 32'h100; addr[1] = 32'h104; wdata[0] = 32'h0A; wdata[1] = 32'h0B;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_valid && o_req_ready != 0) gq.push_back(o_grant == 2'b10 ? 1 : 0);
            tick();
        end
        idle_inputs();
        chk("contend_count", 64'(gq.size()), 64'(4));
        for (int i = 0; i < 4; i++) chk("contend_order", 64'(i < gq.size() ? gq[i] : 99), 64'(exp_g[i]));

        // Single write
        req_valid = 2'b01; req_rw = 2'b01; addr[0] = 32'h10; wdata[0] = 32'hA5A5_0001; i_ready = 1'b1;
        @(negedge clk);
        chk("wr_n_valid", 64'(o_valid), 64'(0));
        tick();
        @(negedge clk);
        chk("wr_valid", 64'(o_valid), 64'(1));
        chk("wr_addr",  64'(o_addr), 64'(32'h10));
        chk("wr_data",  64'(o_wr_data), 64'(32'hA5A5_0001));
        chk("wr_rw",    64'(o_rd0_wr1), 64'(1));
        chk("wr_ready", 64'(o_req_ready), 64'(2'b01));
        chk("wr_grant", 64'(o_grant), 64'(2'b01));
        tick();
        idle_inputs();
        @(negedge clk);
        chk("wr_idle_grant", 64'(o_grant), 64'(0));
        chk("wr_idle_valid", 64'(o_valid), 64'(0));
        tick();

        // Read with data returned three cycles after accept
        req_valid = 2'b10; req_rw = 2'b00; addr[1] = 32'h20; i_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("rd_valid", 64'(o_valid), 64'(1));
        chk("rd_addr",  64'(o_addr), 64'(32'h20));
        chk("rd_ready", 64'(o_req_ready), 64'(2'b10));
        tick();
        idle_inputs();
        pulses = 0; pk = -1; pvec = '0; pdata = '0;
        for (int k = 2; k < 8; k++) begin
            i_rd_valid = (k == 4);
            i_rd_data  = (k == 4) ? 32'hDEAD_BEEF : 32'h1111_2222;
            @(negedge clk);
            if (k == 3) chk("rd_wait_valid", 64'(o_valid), 64'(0));
            if (o_req_rd_valid != 0) begin
                pulses++; pk = k; pvec = o_req_rd_valid; pdata = o_req_rd_data;
            end else begin
                chk("rd_data_quiet", 64'(o_req_rd_data), 64'(0));
            end
            tick();
        end
        idle_inputs();
        chk("rd_pulses", 64'(pulses), 64'(1));
        chk("rd_cycle",  64'(pk), 64'(4));
        chk("rd_vec",    64'(pvec), 64'(2'b10));
        chk("rd_rdata",  64'(pdata), 64'(32'hDEAD_BEEF));

        // Read timeout
        req_valid = 2'b01; req_rw = 2'b00; addr[0] = 32'h30; i_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("to_accept", 64'(o_valid & o_req_ready[0]), 64'(1));
        tick();
        idle_inputs();
        pulses = 0; pk = -1; pvec = '0; perr = '0; pdata = '1;
        for (int k = 2; k < 10; k++) begin
            @(negedge clk);
            if (o_req_rd_valid != 0) begin
                pulses++; pk = k; pvec = o_req_rd_valid; perr = o_req_err; pdata = o_req_rd_data;
            end
            tick();
        end
        chk("to_pulses", 64'(pulses), 64'(1));
        chk("to_delay",  64'(pk - 2), 64'(4));
        chk("to_vec",    64'(pvec), 64'(2'b01));
        chk("to_err",    64'(perr), 64'(2'b01));
        chk("to_data",   64'(pdata), 64'(0));

        // Back-pressure then withdrawal; req1 must be granted next
        req_valid = 2'b01; req_rw = 2'b11; addr[0] = 32'h40; addr[1] = 32'h44; i_ready = 1'b0;
        @(negedge clk);
        tick();
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) req_valid = 2'b11;
            @(negedge clk);
            chk("bp_hold_grant", 64'(o_grant), 64'(2'b01));
            chk("bp_no_ready",   64'(o_req_ready), 64'(0));
            tick();
        end
        req_valid = 2'b10;
        @(negedge clk);
        chk("bp_withdraw_valid", 64'(o_valid), 64'(0));
        tick();
        i_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_grant", 64'(o_grant), 64'(0));
        tick();
        @(negedge clk);
        chk("bp_next_grant", 64'(o_grant), 64'(2'b10));
        chk("bp_next_addr",  64'(o_addr), 64'(32'h44));
        tick();
        idle_inputs();

        // Reset while waiting for read data
        req_valid = 2'b01; req_rw = 2'b00; addr[0] = 32'h50; i_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        idle_inputs();
        @(negedge clk);
        chk("rw_wait_grant", 64'(o_grant), 64'(2'b01));
        tick();
        rstn = 1'b0;
        @(negedge clk);
        chk("rw_rst_valid", 64'(o_req_rd_valid), 64'(0));
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("rw_rst_grant", 64'(o_grant), 64'(0));
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            i_rd_valid = (k == 1);
            i_rd_data  = 32'h77;
            @(negedge clk);
            if (o_req_rd_valid != 0 || o_req_err != 0) pulses++;
        end
        idle_inputs();
        chk("rw_no_pulse", 64'(pulses), 64'(0));
        tick();

        // Read accepted with data in the same cycle
        req_valid = 2'b10; req_rw = 2'b00; addr[1] = 32'h60; i_ready = 1'b1;
        i_rd_valid = 1'b1; i_rd_data = 32'h1234_5678;
        @(negedge clk);
        chk("fast_idle_rdv", 64'(o_req_rd_valid), 64'(0));
        tick();
        @(negedge clk);
        chk("fast_rdv",   64'(o_req_rd_valid), 64'(2'b10));
        chk("fast_rdata", 64'(o_req_rd_data), 64'(32'h1234_5678));
        chk("fast_err",   64'(o_req_err), 64'(0));
        tick();
        idle_inputs();
        @(negedge clk);
        chk("fast_done_grant", 64'(o_grant), 64'(0));
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/txn_arbiter.md
TXN_ARBITER -- requirements
Module: txn_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters (legal range 2..4).
REQ-002 Parameter ADDR_WIDTH, default 32, transaction address width.
REQ-003 Parameter DATA_WIDTH, default 32, transaction data width.
REQ-004 Parameter RD_TIMEOUT, default 255, maximum cycles spent in WAIT_RD before forced completion.
REQ-005 Clock and reset: one clock; reset is synchronous and active-low.
REQ-006 i_clk_apb  in  1  sole clock; all flops on its rising edge.
REQ-007 i_rstn_apb  in  1  synchronous active-low reset.
REQ-008 i_req_valid  in  NUM_REQ  per-requester transaction request.
REQ-009 o_req_ready  out  NUM_REQ  per-requester acceptance.
REQ-010 i_req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester k at slice k.
REQ-011 i_req_rd0_wr1  in  NUM_REQ  0=read, 1=write.
REQ-012 i_req_wr_data  in  NUM_REQ*DATA_WIDTH  packed write data.
REQ-013 o_req_rd_valid  out  NUM_REQ  one-cycle read-return pulse to the granted requester.
REQ-014 o_req_rd_data  out  DATA_WIDTH  read data, broadcast to all requesters.
REQ-015 o_req_err  out  NUM_REQ  one-cycle read-timeout pulse, coincident with o_req_rd_valid.
REQ-016 o_valid, o_addr, o_rd0_wr1, o_wr_data  out  target-side transaction (1, ADDR_WIDTH, 1, DATA_WIDTH).
REQ-017 i_ready, i_rd_valid, i_rd_data  in  target-side accept, read valid, read data (1, 1, DATA_WIDTH).
REQ-018 o_grant  out  NUM_REQ  registered one-hot current grant; all-zero in IDLE.

Function
REQ-019 FSM states: IDLE, GRANT, WAIT_RD.
REQ-020 IDLE: when any i_req_valid is high, select the winner round-robin, starting from the index after last_ptr and wrapping; register o_grant; go to GRANT at the next edge.
REQ-021 Latency: a request seen in IDLE at cycle n drives o_valid at cycle n+1 at the earliest.
REQ-022 GRANT: o_valid = i_req_valid[g]; forward addr, rd0_wr1 and wr_data of g combinationally; o_req_ready[g] = i_ready; all other o_req_ready are 0.
REQ-023 GRANT handshake (o_valid && i_ready), write: set last_ptr=g, go to IDLE.
REQ-024 GRANT handshake, read, with i_rd_valid low: go to WAIT_RD and clear the timeout counter.
REQ-025 GRANT handshake, read, with i_rd_valid high in the same cycle: pulse o_req_rd_valid[g] with data = i_rd_data, set last_ptr=g, go to IDLE.
REQ-026 GRANT with i_req_valid[g] low (request withdrawn): set last_ptr=g, go to IDLE; nothing is issued.
REQ-027 WAIT_RD: o_valid=0; on i_rd_valid, pulse o_req_rd_valid[g], drive o_req_rd_data=i_rd_data for that cycle, set last_ptr=g, go to IDLE.
REQ-028 WAIT_RD: the counter increments each cycle; when it reaches RD_TIMEOUT with no i_rd_valid, pulse o_req_rd_valid[g] and o_req_err[g] with data 0, then go to IDLE.
REQ-029 i_rd_valid outside WAIT_RD and outside the REQ-025 case is ignored.
REQ-030 o_req_rd_data = 0 in every cycle with no o_req_rd_valid pulse.
REQ-031 Grant is held until completion; a higher-priority request never preempts an active grant.
REQ-032 Counter width is $clog2(RD_TIMEOUT+1); the counter never wraps.

Reset
REQ-033 Reset low at a clock edge: state=IDLE, o_grant=0, last_ptr=NUM_REQ-1 (requester 0 wins first), counter=0.
REQ-034 During reset all outputs are 0 (o_valid, o_req_ready, o_req_rd_valid, o_req_err, o_addr, o_wr_data, o_req_rd_data).
REQ-035 Reset mid-transaction abandons it silently: no rd_valid or err pulse.

Structure
REQ-036 Shared package apb_txn_pkg holds the arb_state_t enum (IDLE, GRANT, WAIT_RD) and the default width constants.
REQ-037 One combinational sub-module, rr_picker (request vector plus last_ptr in, one-hot winner out); all flops live in txn_arbiter.

Verification
REQ-038 Single write: req0 write addr 0x10, data 0xA5A5_0001, i_ready=1 -> o_valid high for one cycle at n+1 with matching fields; o_req_ready[0] pulse; back in IDLE at n+2.
REQ-039 Contention: req0 and req1 write continuously, i_ready=1 -> grants alternate 0,1,0,1 across 4 transactions.
REQ-040 Read with 3-cycle return: req1 read 0x20; i_rd_valid 3 cycles after accept with data 0xDEAD_BEEF -> single o_req_rd_valid[1] pulse carrying 0xDEAD_BEEF; o_req_rd_data=0 on all other cycles.
REQ-041 Read timeout: RD_TIMEOUT=4, i_rd_valid never asserted -> o_req_rd_valid[0] and o_req_err[0] pulse 4 cycles after entering WAIT_RD, data 0.
REQ-042 Back-pressure and withdrawal: i_ready=0 for 5 cycles, then req0 drops valid -> return to IDLE with no target handshake; next grant goes to req1.
REQ-043 Reset in WAIT_RD -> state IDLE and all outputs 0 on the next edge; no pulses follow.
